// File: rtl/iq_capture_sequencer.sv
// IQ capture sequencer: gates a packed {Q,I} stream into fixed-length
// packets on a software start, optionally waiting for an external trigger.
module iq_capture_sequencer #(
   parameter int DATA_W = 32,
   parameter int LEN_W  = 16
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              start,
   input  logic              abort,
   input  logic              trig_mode,
   input  logic              trig_in,
   input  logic [LEN_W-1:0]  capture_len,
   input  logic [DATA_W-1:0] s00_axis_tdata,
   input  logic              s00_axis_tvalid,
   output logic              s00_axis_tready,
   output logic [DATA_W-1:0] m00_axis_tdata,
   output logic              m00_axis_tvalid,
   input  logic              m00_axis_tready,
   output logic              m00_axis_tlast,
   output logic              busy,
   output logic              done,
   output logic              aborted,
   output logic [LEN_W-1:0]  sample_count
);

   typedef enum logic [1:0] {IDLE, ARMED, RUN, FLUSH} state_t;

   state_t             state;
   state_t             state_nx;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   acc_cnt;
   logic [DATA_W-1:0]  out_data;
   logic               out_valid;
   logic               out_last;
   logic               s_ready;
   logic               in_hs;
   logic               out_hs;
   logic               load;
   logic               start_ok;
   logic               last_beat;
   logic               done_nx;

   assign out_hs    = out_valid && m00_axis_tready;
   assign in_hs     = s00_axis_tvalid && s_ready;
   assign load      = (state == RUN) && in_hs;
   assign start_ok  = (state == IDLE) && start && !abort
                      && (capture_len != '0);
   assign last_beat = (acc_cnt == len_q - 1'b1);

   // Outside a capture the input is drained so the ADC never stalls.
   always_comb begin
      s_ready = 1'b0;
      unique case (state)
         IDLE:    s_ready = 1'b1;
         ARMED:   s_ready = 1'b1;
         RUN:     s_ready = !abort && (!out_valid || m00_axis_tready);
         FLUSH:   s_ready = 1'b0;
         default: s_ready = 1'b0;
      endcase
   end

   assign s00_axis_tready = s_ready && !areset;

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (start_ok) state_nx = trig_mode ? ARMED : RUN;
         end
         ARMED: begin
            if (abort)        state_nx = IDLE;
            else if (trig_in) state_nx = RUN;
         end
         RUN: begin
            if (abort)
               state_nx = (out_valid && !m00_axis_tready) ? FLUSH : IDLE;
            else if (load && last_beat)
               state_nx = FLUSH;
         end
         FLUSH: begin
            if (out_hs) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      done_nx = (state == FLUSH) && out_hs && !aborted && !abort;
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else if (load) begin
         out_data  <= s00_axis_tdata;
         out_valid <= 1'b1;
         out_last  <= last_beat;
      end else if (out_hs) begin
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         len_q        <= '0;
         acc_cnt      <= '0;
         sample_count <= '0;
         aborted      <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= done_nx;
         if (start_ok) begin
            len_q        <= capture_len;
            acc_cnt      <= '0;
            sample_count <= '0;
            aborted      <= 1'b0;
         end else begin
            if (load) acc_cnt <= acc_cnt + 1'b1;
            if (out_hs && (sample_count != '1))
               sample_count <= sample_count + 1'b1;
            if (abort && (state == RUN || state == FLUSH))
               aborted <= 1'b1;
         end
      end
   end

   assign m00_axis_tdata  = out_data;
   assign m00_axis_tvalid = out_valid;
   assign m00_axis_tlast  = out_last;

endmodule

// File: tb/tb_iq_capture_sequencer.sv
// Bench for iq_capture_sequencer: packet-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_iq_capture_sequencer;

   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        trig_mode = 1'b0;
   logic        trig_in = 1'b0;
   logic [15:0] capture_len = '0;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic        m_last;
   logic        busy;
   logic        done;
   logic        aborted;
   logic [15:0] sample_count;

   iq_capture_sequencer #(.DATA_W(32), .LEN_W(16)) dut (
      .aclk            (aclk),
      .areset          (areset),
      .start           (start),
      .abort           (abort),
      .trig_mode       (trig_mode),
      .trig_in         (trig_in),
      .capture_len     (capture_len),
      .s00_axis_tdata  (s_data),
      .s00_axis_tvalid (s_valid),
      .s00_axis_tready (s_ready),
      .m00_axis_tdata  (m_data),
      .m00_axis_tvalid (m_valid),
      .m00_axis_tready (m_ready),
      .m00_axis_tlast  (m_last),
      .busy            (busy),
      .done            (done),
      .aborted         (aborted),
      .sample_count    (sample_count)
   );

   always #5 aclk = ~aclk;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Model: phase 0 idle, 1 waiting for trigger, 2 capturing, 3 draining.
   int          ph = 0;
   logic [15:0] left = '0;
   logic [15:0] mcnt = '0;
   logic        mdone = 1'b0;
   logic        mab = 1'b0;
   logic [32:0] pend[$];
   logic [31:0] got[$];
   logic        got_last[$];
   int          n_done = 0;

   always @(negedge aclk) begin : cmp
      logic e_rdy;
      logic mhs;
      logic acc;
      if (areset) begin
         ph = 0; left = '0; mcnt = '0; mdone = 1'b0; mab = 1'b0;
         pend.delete();
      end
      case (ph)
         0, 1: e_rdy = !areset;
         2:    e_rdy = !abort && (pend.size() == 0 || m_ready);
         default: e_rdy = 1'b0;
      endcase
      chk("s_tready", s_ready, e_rdy);
      chk("m_tvalid", m_valid, pend.size() != 0);
      if (pend.size() != 0) begin
         chk("m_tdata", m_data, pend[0][31:0]);
         chk("m_tlast", m_last, pend[0][32]);
      end
      chk("busy", busy, ph != 0);
      chk("done", done, mdone);
      chk("aborted", aborted, mab);
      chk("sample_count", sample_count, mcnt);
      if (m_valid && m_ready) begin
         got.push_back(m_data);
         got_last.push_back(m_last);
      end
      if (done) n_done++;
      if (!areset) begin
         mhs = (pend.size() != 0) && m_ready;
         acc = s_valid && e_rdy;
         mdone = 1'b0;
         if (mhs) begin
            void'(pend.pop_front());
            if (mcnt != 16'hFFFF) mcnt++;
         end
         case (ph)
            0: if (start && !abort && capture_len != 0) begin
               left = capture_len; mcnt = '0; mab = 1'b0;
               ph = trig_mode ? 1 : 2;
            end
            1: if (abort) ph = 0;
               else if (trig_in) ph = 2;
            2: if (abort) begin
               mab = 1'b1;
               ph = (pend.size() != 0) ? 3 : 0;
            end else if (acc) begin
               pend.push_back({left == 16'd1, s_data});
               left--;
               if (left == 0) ph = 3;
            end
            default: begin
               if (mhs) begin
                  mdone = !(mab || abort);
                  ph = 0;
               end
               if (abort) mab = 1'b1;
            end
         endcase
      end
   end

   task automatic tick();
      logic hs;
      @(negedge aclk);
      hs = s_valid && s_ready;
      @(posedge aclk);
      #1;
      if (hs) s_data += 32'h0001_0000;
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic go(input logic [15:0] l, input logic tm);
      got.delete();
      got_last.delete();
      n_done = 0;
      s_data = '0;
      capture_len = l;
      trig_mode = tm;
      start = 1'b1;
      tick();
   endtask

   task automatic wait_done(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (!busy && !m_valid) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_done: still busy after %0d cycles", budget);
      end
      tick();
   endtask

   task automatic chk_pkt(input string name, input int n);
      chk({name, "_len"}, got.size(), n);
      if (got.size() == n)
         for (int i = 0; i < n; i++)
            chk({name, "_tlast"}, got_last[i], i == n - 1);
   endtask

   initial begin
      #1;
      chk("rst_tready", s_ready, 0);
      chk("rst_tvalid", m_valid, 0);
      chk("rst_tdata", m_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", sample_count, 0);
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;
      s_valid = 1'b1;
      m_ready = 1'b1;
      repeat (3) tick();

      // plain capture of 4 beats
      go(16'd4, 1'b0);
      chk("t1_lat0", m_valid, 0);
      tick();
      chk("t1_first_valid", m_valid, 1);
      chk("t1_first_data", m_data, 32'h0001_0000);
      wait_done(30);
      chk_pkt("t1", 4);
      if (got.size() == 4) chk("t1_last_data", got[3], 32'h0004_0000);
      chk("t1_count", sample_count, 4);
      chk("t1_done", n_done, 1);

      // triggered capture of 3 beats
      go(16'd3, 1'b1);
      repeat (10) tick();
      chk("t2_armed_ready", s_ready, 1);
      trig_in = 1'b1;
      tick();
      trig_in = 1'b0;
      trig_mode = 1'b0;
      wait_done(30);
      chk_pkt("t2", 3);
      if (got.size() == 3) begin
         chk("t2_first", got[0], 32'h000C_0000);
         chk("t2_third", got[2], 32'h000E_0000);
      end

      // downstream ready toggling
      go(16'd8, 1'b0);
      for (int i = 0; i < 40 && busy; i++) begin
         m_ready = ~m_ready;
         tick();
      end
      m_ready = 1'b1;
      wait_done(30);
      chk_pkt("t3", 8);
      if (got.size() == 8) chk("t3_last_data", got[7], 32'h0008_0000);

      // abort with a stalled pending beat
      go(16'd100, 1'b0);
      for (int i = 0; i < 30 && got.size() < 5; i++) tick();
      m_ready = 1'b0;
      abort = 1'b1;
      tick();
      tick();
      chk("t4_aborted", aborted, 1);
      chk("t4_pending", m_valid, 1);
      chk("t4_no_tlast", m_last, 0);
      chk("t4_busy", busy, 1);
      m_ready = 1'b1;
      wait_done(30);
      chk("t4_len", got.size(), 6);
      if (got.size() == 6) chk("t4_data", got[5], 32'h0006_0000);
      chk("t4_count", sample_count, 6);
      chk("t4_done", n_done, 0);

      // zero length, start with abort, restart while busy
      go(16'd0, 1'b0);
      chk("t5_len0_busy", busy, 0);
      capture_len = 16'd3;
      start = 1'b1;
      abort = 1'b1;
      tick();
      chk("t5_abort_wins", busy, 0);
      go(16'd5, 1'b0);
      tick();
      capture_len = 16'd9;
      start = 1'b1;
      tick();
      wait_done(30);
      chk_pkt("t5", 5);
      chk("t5_count", sample_count, 5);

      // asynchronous reset mid-capture
      go(16'd10, 1'b0);
      tick();
      tick();
      areset = 1'b1;
      #1;
      chk("t6_tvalid", m_valid, 0);
      chk("t6_tready", s_ready, 0);
      chk("t6_tdata", m_data, 0);
      chk("t6_tlast", m_last, 0);
      chk("t6_busy", busy, 0);
      chk("t6_count", sample_count, 0);
      tick();
      areset = 1'b0;
      #1;
      chk("t6_idle_ready", s_ready, 1);
      chk("t6_idle_busy", busy, 0);
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/iq_capture_sequencer.md
Name: iq_capture_sequencer

Overview:
- Sequences the packed 32-bit IQ stream ({Q[15:0], I[15:0]}) on its way to the DMA/DAC sink.
- On a software start, with an optional external trigger, it passes exactly capture_len IQ beats and marks the last beat with tlast.
- While not capturing, it drains and discards the input stream so the ADC side never stalls.
- A one-stage registered output decouples the upstream and downstream ready paths.

Parameters:
DATA_W, 32, IQ beat width ({Q,I}, 16+16)
LEN_W, 16, width of capture length and counters

Ports:
aclk  in  1  clock for all logic
areset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a capture when idle
abort  in  1  one-cycle pulse; ends the capture early
trig_mode  in  1  0 = start immediately, 1 = wait for trig_in
trig_in  in  1  external trigger, level-sampled
capture_len  in  LEN_W  beats per capture; sampled on an accepted start
s00_axis_tdata  in  DATA_W  packed IQ input
s00_axis_tvalid  in  1  input valid
s00_axis_tready  out  1  input ready
m00_axis_tdata  out  DATA_W  IQ output
m00_axis_tvalid  out  1  output valid
m00_axis_tready  in  1  output ready
m00_axis_tlast  out  1  high on the final beat of a capture
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse when a full capture completes
aborted  out  1  sticky; set by abort, cleared by the next accepted start
sample_count  out  LEN_W  beats handshaked on m00 in the current capture

Behaviour:
- Reset (areset=1, asynchronous): state IDLE.
  - All outputs 0, including s00_axis_tready, m00_axis_tvalid, tlast, busy, done, aborted and sample_count.
  - Output register and the latched length are cleared.
- States: IDLE, ARMED, RUN, FLUSH.
- IDLE:
  - s00_axis_tready=1; accepted beats are discarded.
  - start with capture_len!=0: latch the length, clear sample_count and aborted, go to ARMED if trig_mode=1, else RUN.
  - start with capture_len==0 is ignored.
- ARMED:
  - s00_axis_tready=1; beats are discarded.
  - trig_in=1 sampled: go to RUN next cycle. A beat accepted in the trigger cycle is discarded.
- RUN:
  - s00_axis_tready = !m00_axis_tvalid || m00_axis_tready.
  - Each accepted beat loads the output register: tvalid=1 the next cycle, latency 1.
  - Internal accept counter increments per accepted beat.
  - The beat accepted when accept count == len-1 is loaded with tlast=1; state goes to FLUSH.
  - Full throughput: 1 beat/cycle while downstream is ready.
- FLUSH:
  - s00_axis_tready=0.
  - When the pending output beat handshakes: tvalid=0; pulse done if not aborted; go to IDLE.
- m00 AXIS rules:
  - tdata, tlast and tvalid are stable while tvalid=1 and tready=0.
  - tvalid never deasserts without a handshake.
- sample_count increments on each m00 handshake. It saturates at all-ones, holds after completion, and is cleared only on an accepted start.
- abort:
  - From ARMED: go to IDLE next cycle.
  - From RUN: set aborted; stop accepting (go to FLUSH). A pending output beat completes unchanged (no forced tlast); no done pulse. If no beat is pending, go straight to IDLE.
  - In IDLE: no effect. In FLUSH: only sets aborted.
  - abort and start in the same cycle: abort wins; start is ignored.
- start while busy=1: ignored; capture_len changes mid-capture have no effect.
- Counter widths: capture_len up to 2^LEN_W-1. Compare on equality, so there is no wrap within a capture.
- areset asserted mid-capture: immediate return to reset values; the partial packet is lost with no tlast.

Test Plan:
- Reset, then start with trig_mode=0, capture_len=4, input valid every cycle (data 0x00010000..) with m00 tready=1 -> 4 beats out, the first 1 cycle after the first accept; tlast only on the 4th (0x00040000 if sequential); done pulse 1 cycle after the last handshake; sample_count=4.
- trig_mode=1, len=3, trig_in asserted 10 cycles later, input streaming -> beats before and during the trigger cycle are discarded with tready=1; exactly 3 beats after the trigger; tlast on the 3rd.
- len=8; m00 tready toggles 1010…, input valid constant -> no beat lost or duplicated; tdata/tlast stable while stalled; s00 tready = !tvalid||m00_tready every cycle.
- len=100; abort after 5 output handshakes with one beat pending and stalled -> pending beat delivered without tlast; aborted=1; no done; busy falls after the handshake; sample_count=6.
- start with capture_len=0 -> busy stays 0; start during RUN with a different len -> ignored, the original length completes.
- areset pulsed mid-RUN with tvalid=1 -> all outputs 0 immediately; back in IDLE the next cycle with s00 tready=1.
